ntt_address_generator: RTL and testbench
========================================

Name: ntt_address_generator

Overview:
- Upstream address sequencer for the radix-2 NTT core. Per run it walks all LOGN Cooley-Tukey stages and emits one butterfly address pair per cycle, plus the twiddle index and stage tags.
- old_address_0/old_address_1 feed conflict_free_memory_map directly.
- The pair always differs by a power of two, so the parity-based bank numbers of the two addresses always differ.
- A programmable gap between stages lets the butterfly pipeline drain before the next stage reads.

Parameters:
LOGN, 10, log2 of transform length N (N=1024); address width.
STAGE_GAP, 4, idle cycles inserted between consecutive stages (0 allowed).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; synchronous, active-low.
start  in  1  run request; sampled only in IDLE.
stall  in  1  freeze request from downstream; holds all counters and outputs.
old_address_0  out  LOGN  butterfly upper-input address.
old_address_1  out  LOGN  butterfly lower-input address (= old_address_0 + d).
twiddle_index  out  LOGN  bit-reversed-order twiddle index.
stage  out  4  current stage s, 0..LOGN-1.
addr_valid  out  1  address pair valid this cycle.
last_in_stage  out  1  high with the final pair of a stage.
busy  out  1  high in RUN, GAP and DONE.
done  out  1  one-cycle pulse at end of run.

Behaviour:
- All outputs registered. While rst=0 at a clock edge: state=IDLE; every output is 0; counters s, k and gap are 0.
- States: IDLE, RUN, GAP, DONE.
- IDLE:
  - start=1 -> RUN with s=0, k=0.
  - The first addr_valid=1 appears in the cycle after start is sampled.
- RUN: each non-stalled cycle presents the pair for (s,k) with addr_valid=1, then advances k. k runs 0..N/2-1.
- Arithmetic, truncated to LOGN bits:
  - d = N>>(s+1)
  - g = k>>(LOGN-1-s)
  - j = k & (d-1)
  - old_address_0 = g*2d + j
  - old_address_1 = old_address_0 + d
  - twiddle_index = (1<<s) + g
- Stage end: last_in_stage=1 when k=N/2-1. At that point k wraps to 0 and:
  - if s<LOGN-1: s increments; go to GAP, or straight to RUN if STAGE_GAP=0.
  - if s=LOGN-1: go to DONE.
- GAP:
  - addr_valid=0; address outputs hold their last values.
  - Counts STAGE_GAP cycles, then returns to RUN.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. busy=0 from that IDLE cycle onward.
- stall=1 in RUN or GAP:
  - addr_valid=0; last_in_stage=0.
  - k, s and the gap counter hold; addresses hold.
  - Release resumes at the same (s,k) with no skip and no repeat.
- stall is ignored in IDLE and DONE.
- start while busy: ignored; no restart, no queueing.
- start and stall both high in IDLE: the run starts; stall applies from the next cycle.
- rst=0 mid-run: immediate return to IDLE at that edge. No done pulse is produced.
- Run length without stalls: (LOGN*N/2) + (LOGN-1)*STAGE_GAP cycles of RUN/GAP, then 1 DONE cycle. Defaults: 5120 + 36 = 5156, then 1.
- Invariant: old_address_0 and old_address_1 have different XOR-parity on every valid cycle.

Test Plan:
- Reset, then start pulse at cycle 0 -> cycle 1: addr_valid=1, stage=0, addresses (0,512), twiddle_index=1. Cycle 2: (1,513), twiddle_index=1. Cycle 512: (511,1023), last_in_stage=1.
- Default run continued -> addr_valid=0 for exactly 4 cycles after stage 0. Next pair: stage=1, (0,256), twiddle_index=2. Stage 1, k=256: (512,768), twiddle_index=3.
- Final stage -> stage=9, k=511: (1022,1023), twiddle_index=1023, last_in_stage=1. Then done=1 for one cycle and busy falls. Total 5120 valid pairs; every pair's parity differs.
- stall=1 for 3 cycles at stage 2, k=100 -> addr_valid=0 and outputs frozen for those cycles. After release the next pair is k=100: (228,356), twiddle_index=4. Valid-pair count stays 5120.
- STAGE_GAP=0 build -> stage 0 k=511 is immediately followed by stage 1 (0,256) with no gap. Run is 5120 cycles, then done.
- start pulsed while busy, and rst=0 during stage 3 -> start is ignored. After reset: all outputs 0, no done pulse, and a new start restarts at stage 0, (0,512).

Source files
------------

// File: rtl/ntt_address_generator.sv
// ntt_address_generator
// Address sequencer for a radix-2 Cooley-Tukey NTT core. A run walks every
// stage and emits one butterfly address pair per cycle. Each pair comes with
// its twiddle index and stage tag. An optional idle gap between stages lets
// the butterfly pipeline drain. All outputs are registered.
module ntt_address_generator #(
    parameter int LOGN      = 10,
    parameter int STAGE_GAP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    output logic [LOGN-1:0] old_address_0,
    output logic [LOGN-1:0] old_address_1,
    output logic [LOGN-1:0] twiddle_index,
    output logic [3:0]      stage,
    output logic            addr_valid,
    output logic            last_in_stage,
    output logic            busy,
    output logic            done
);

    localparam int HALF = 1 << (LOGN - 1);
    localparam int GW   = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [LOGN-2:0] K_LAST   = (LOGN-1)'(HALF - 1);
    localparam logic [3:0]      S_LAST   = 4'(LOGN - 1);
    localparam logic [GW-1:0]   GAP_LAST = GW'((STAGE_GAP > 0) ? (STAGE_GAP - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [3:0]      s_r, s_s;
    logic [LOGN-2:0] k_r, k_s;
    logic [GW-1:0]   gap_r, gap_s;

    logic            emit_s;
    logic            k_last_s;
    logic            s_last_s;

    logic [3:0]      sh_s;
    logic [4:0]      sh1_s;
    logic [LOGN-1:0] k_ext_s;
    logic [LOGN-1:0] d_s;
    logic [LOGN-1:0] g_s;
    logic [LOGN-1:0] j_s;
    logic [LOGN-1:0] a0_s;

    logic [LOGN-1:0] a0_n_s, a1_n_s, tw_n_s;
    logic [3:0]      stage_n_s;
    logic            valid_n_s, last_n_s, busy_n_s, done_n_s;

    // Butterfly arithmetic for the current (s,k); the pair stride d is a power of two
    always_comb begin
        sh_s    = S_LAST - s_r;
        sh1_s   = {1'b0, sh_s} + 5'd1;
        k_ext_s = LOGN'(k_r);
        d_s     = LOGN'(1) << sh_s;
        g_s     = k_ext_s >> sh_s;
        j_s     = k_ext_s & (d_s - LOGN'(1));
        a0_s    = (g_s << sh1_s) + j_s;
    end

    // A pair is emitted on a non-stalled RUN edge, or on the edge that accepts start
    always_comb begin
        emit_s   = ((state_r == RUN) && !stall) || ((state_r == IDLE) && start);
        k_last_s = (k_r == K_LAST);
        s_last_s = (s_r == S_LAST);
    end

    // State register: FSM state, (s,k,gap) counters and the registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            s_r           <= 4'd0;
            k_r           <= '0;
            gap_r         <= '0;
            old_address_0 <= '0;
            old_address_1 <= '0;
            twiddle_index <= '0;
            stage         <= 4'd0;
            addr_valid    <= 1'b0;
            last_in_stage <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_r       <= state_s;
            s_r           <= s_s;
            k_r           <= k_s;
            gap_r         <= gap_s;
            old_address_0 <= a0_n_s;
            old_address_1 <= a1_n_s;
            twiddle_index <= tw_n_s;
            stage         <= stage_n_s;
            addr_valid    <= valid_n_s;
            last_in_stage <= last_n_s;
            busy          <= busy_n_s;
            done          <= done_n_s;
        end
    end

    // Next-state logic: advance k, then s, and route through GAP or DONE at stage ends
    always_comb begin
        state_s = state_r;
        s_s     = s_r;
        k_s     = k_r;
        gap_s   = gap_r;
        case (state_r)
            IDLE, RUN: begin
                if (emit_s) begin
                    if (k_last_s) begin
                        k_s   = '0;
                        gap_s = '0;
                        if (s_last_s) begin
                            s_s     = 4'd0;
                            state_s = DONE;
                        end else begin
                            s_s     = s_r + 4'd1;
                            state_s = (STAGE_GAP == 0) ? RUN : GAP;
                        end
                    end else begin
                        k_s     = k_r + (LOGN-1)'(1);
                        state_s = RUN;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            GAP: begin
                if (stall) begin
                    gap_s = gap_r;
                end else if (gap_r == GAP_LAST) begin
                    gap_s   = '0;
                    state_s = RUN;
                end else begin
                    gap_s = gap_r + GW'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
                s_s     = 4'd0;
                k_s     = '0;
                gap_s   = '0;
            end
            default: begin
                state_s = IDLE;
                s_s     = 4'd0;
                k_s     = '0;
                gap_s   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs; addresses hold unless a pair is emitted
    always_comb begin
        a0_n_s    = old_address_0;
        a1_n_s    = old_address_1;
        tw_n_s    = twiddle_index;
        stage_n_s = stage;
        valid_n_s = 1'b0;
        last_n_s  = 1'b0;
        busy_n_s  = 1'b0;
        done_n_s  = 1'b0;
        case (state_r)
            IDLE: busy_n_s = start;
            RUN:  busy_n_s = 1'b1;
            GAP:  busy_n_s = 1'b1;
            DONE: begin
                busy_n_s = 1'b1;
                done_n_s = 1'b1;
            end
            default: busy_n_s = 1'b0;
        endcase
        if (emit_s) begin
            a0_n_s    = a0_s;
            a1_n_s    = a0_s + d_s;
            tw_n_s    = (LOGN'(1) << s_r) + g_s;
            stage_n_s = s_r;
            valid_n_s = 1'b1;
            last_n_s  = k_last_s;
        end else begin
            valid_n_s = 1'b0;
            last_n_s  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ntt_address_generator.sv
// Directed bench for ntt_address_generator (N=1024). dut runs with the default
// stage gap. dut0 is built with no stage gap. A negedge scoreboard re-derives
// every valid pair of dut from an independent reference model.
module tb_ntt_address_generator;

    localparam int LOGN = 10;
    localparam int N    = 1 << LOGN;

    logic       clk = 1'b0;
    logic       rst, start, stall, start2;
    logic [9:0] a0, a1, tw, a0b, a1b, twb;
    logic [3:0] stg, stgb;
    logic       vld, lst, bsy, dn, vldb, lstb, bsyb, dnb;

    int n_cmp = 0;
    int n_err = 0;
    int mon_err = 0;
    int pairs = 0;
    int ms = 0;
    int mk = 0;

    ntt_address_generator #(.LOGN(10), .STAGE_GAP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .old_address_0(a0), .old_address_1(a1), .twiddle_index(tw), .stage(stg),
        .addr_valid(vld), .last_in_stage(lst), .busy(bsy), .done(dn)
    );

    ntt_address_generator #(.LOGN(10), .STAGE_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start2), .stall(1'b0),
        .old_address_0(a0b), .old_address_1(a1b), .twiddle_index(twb), .stage(stgb),
        .addr_valid(vldb), .last_in_stage(lstb), .busy(bsyb), .done(dnb)
    );

    always #5 clk = ~clk;

    // Reference model: d = half-span of stage s, g = group, j = offset in group
    function automatic int ref_d(input int s);
        return (N / 2) >> s;
    endfunction
    function automatic int ref_a0(input int s, input int k);
        return ((k / ref_d(s)) * 2 * ref_d(s) + (k % ref_d(s))) % N;
    endfunction
    function automatic int ref_a1(input int s, input int k);
        return (ref_a0(s, k) + ref_d(s)) % N;
    endfunction
    function automatic int ref_tw(input int s, input int k);
        return ((1 << s) + k / ref_d(s)) % N;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid pair of dut matches the model and has differing parity
    always @(negedge clk) begin
        if (!rst) begin
            ms    <= 0;
            mk    <= 0;
            pairs <= 0;
        end else if (vld) begin
            if (a0 !== 10'(ref_a0(ms, mk)) || a1 !== 10'(ref_a1(ms, mk)) ||
                tw !== 10'(ref_tw(ms, mk)) || stg !== 4'(ms) ||
                lst !== (mk == N / 2 - 1) || (^a0) === (^a1))
                mon_err <= mon_err + 1;
            pairs <= pairs + 1;
            if (mk == N / 2 - 1) begin
                mk <= 0;
                ms <= (ms == LOGN - 1) ? 0 : ms + 1;
            end else begin
                mk <= mk + 1;
            end
        end
    end

    initial begin
        int cyc;
        bit seen;
        rst = 1'b0; start = 1'b0; stall = 1'b0; start2 = 1'b0;
        tick();
        tick();
        chk("reset_valid", 32'(vld), 32'd0);
        chk("reset_busy", 32'(bsy), 32'd0);
        chk("reset_addr0", 32'(a0), 32'd0);
        chk("reset_tw", 32'(tw), 32'd0);
        rst = 1'b1;
        tick();

        // First stage: start pulse, first pairs, last pair of stage 0
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_valid", 32'(vld), 32'd1);
        chk("c1_addr0", 32'(a0), 32'd0);
        chk("c1_addr1", 32'(a1), 32'd512);
        chk("c1_tw", 32'(tw), 32'd1);
        chk("c1_busy", 32'(bsy), 32'd1);
        tick();
        chk("c2_addr0", 32'(a0), 32'd1);
        chk("c2_addr1", 32'(a1), 32'd513);
        chk("c2_tw", 32'(tw), 32'd1);
        for (int i = 0; i < 510; i++) tick();
        chk("c512_addr0", 32'(a0), 32'd511);
        chk("c512_addr1", 32'(a1), 32'd1023);
        chk("c512_last", 32'(lst), 32'd1);

        // Stage gap of 4 idle cycles, then stage 1
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap_valid", 32'(vld), 32'd0);
        end
        tick();
        chk("s1k0_valid", 32'(vld), 32'd1);
        chk("s1k0_stage", 32'(stg), 32'd1);
        chk("s1k0_addr0", 32'(a0), 32'd0);
        chk("s1k0_addr1", 32'(a1), 32'd256);
        chk("s1k0_tw", 32'(tw), 32'd2);
        for (int i = 0; i < 256; i++) tick();
        chk("s1k256_addr0", 32'(a0), 32'd512);
        chk("s1k256_addr1", 32'(a1), 32'd768);
        chk("s1k256_tw", 32'(tw), 32'd3);

        // Stall for 3 cycles ahead of stage 2, k=100
        cyc = 0;
        while (!(vld && stg == 4'd2) && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("s2_reached", 32'(cyc < 2000), 32'd1);
        for (int i = 0; i < 99; i++) tick();
        chk("s2k99_addr0", 32'(a0), 32'd99);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(vld), 32'd0);
            chk("stall_addr0", 32'(a0), 32'd99);
            chk("stall_addr1", 32'(a1), 32'd227);
        end
        stall = 1'b0;
        tick();
        chk("s2k100_valid", 32'(vld), 32'd1);
        chk("s2k100_addr0", 32'(a0), 32'd100);
        chk("s2k100_addr1", 32'(a1), 32'd228);
        chk("s2k100_tw", 32'(tw), 32'd4);

        // Final pair of the last stage, then the done pulse
        cyc = 0;
        while (!(vld && lst && stg == 4'd9) && cyc < 6000) begin
            tick();
            cyc++;
        end
        chk("s9_reached", 32'(cyc < 6000), 32'd1);
        chk("s9k511_addr0", 32'(a0), 32'd1022);
        chk("s9k511_addr1", 32'(a1), 32'd1023);
        chk("s9k511_tw", 32'(tw), 32'd1023);
        tick();
        chk("done_pulse", 32'(dn), 32'd1);
        chk("done_busy", 32'(bsy), 32'd1);
        chk("done_valid", 32'(vld), 32'd0);
        tick();
        chk("after_done", 32'(dn), 32'd0);
        chk("after_busy", 32'(bsy), 32'd0);
        chk("pair_count", 32'(pairs), 32'd5120);

        // No-gap build: stage 1 follows stage 0 directly, run is 5120 cycles
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("g0_c1_addr1", 32'(a1b), 32'd512);
        for (int i = 0; i < 511; i++) tick();
        chk("g0_c512_last", 32'(lstb), 32'd1);
        chk("g0_c512_addr0", 32'(a0b), 32'd511);
        tick();
        chk("g0_c513_valid", 32'(vldb), 32'd1);
        chk("g0_c513_stage", 32'(stgb), 32'd1);
        chk("g0_c513_addr1", 32'(a1b), 32'd256);
        cyc = 513;
        while (!dnb && cyc < 6000) begin
            tick();
            cyc++;
        end
        chk("g0_done_cycle", 32'(cyc), 32'd5121);
        tick();
        chk("g0_after_busy", 32'(bsyb), 32'd0);

        // Start while busy is ignored; reset mid-run; restart from scratch
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r2_c1_addr0", 32'(a0), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_addr0", 32'(a0), 32'd1);
        chk("busy_start_addr1", 32'(a1), 32'd513);
        cyc = 0;
        while (!(vld && stg == 4'd3) && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk("s3_reached", 32'(cyc < 3000), 32'd1);
        rst = 1'b0;
        tick();
        chk("mrst_valid", 32'(vld), 32'd0);
        chk("mrst_busy", 32'(bsy), 32'd0);
        chk("mrst_stage", 32'(stg), 32'd0);
        chk("mrst_addr1", 32'(a1), 32'd0);
        chk("mrst_tw", 32'(tw), 32'd0);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dn || bsy) seen = 1'b1;
        end
        chk("mrst_no_done", 32'(seen), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_stage", 32'(stg), 32'd0);
        chk("restart_addr0", 32'(a0), 32'd0);
        chk("restart_addr1", 32'(a1), 32'd512);
        tick();
        tick();
        chk("scoreboard", 32'(mon_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
